// File: rtl/regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_sched
// Purpose  : Arbitrates the register file write port between WB and the
//            long-latency path, and tracks pending LL writes per register.
// Option   : REGFILE_WRITE_SCHED_HAZARD_CHECK_EN builds the sticky hazard flag.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [SEL_WIDTH-1:0]  wb_sel,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_stall,
  input  logic                  ll_valid,
  input  logic [SEL_WIDTH-1:0]  ll_sel,
  input  logic [DATA_WIDTH-1:0] ll_data,
  output logic                  ll_ready,
  input  logic                  mark_en,
  input  logic [SEL_WIDTH-1:0]  mark_sel,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  rf_write_en,
  output logic [SEL_WIDTH-1:0]  rf_write_sel,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  hazard_err
);

  localparam int WAIT_W = (MAX_WAIT < 4) ? 2 : (MAX_WAIT < 8) ? 3 : 4;
  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic                  wb_real;
  logic                  ll_real;
  logic                  force_ll;
  logic                  grant_ll;
  logic                  grant_wb;

  logic [WAIT_W-1:0]     wait_cnt_d,      wait_cnt_q;
  logic                  rf_write_en_d,   rf_write_en_q;
  logic [SEL_WIDTH-1:0]  rf_write_sel_d,  rf_write_sel_q;
  logic [DATA_WIDTH-1:0] rf_write_data_d, rf_write_data_q;
  logic [NUM_REGS-1:0]   busy_d,          busy_q;

  always_comb begin
    wb_real  = wb_valid & (wb_sel != '0);
    ll_real  = ll_valid & (ll_sel != '0);
    force_ll = ll_real & (wait_cnt_q == C_MAX_WAIT);
    grant_ll = ll_real & (~wb_real | force_ll);
    grant_wb = wb_real & ~grant_ll;
  end

  // Handshake outputs are forced low while reset is held, not just after it.
  assign ll_ready = ~rst & ll_valid & ((ll_sel == '0) | grant_ll);
  assign wb_stall = ~rst & wb_real & grant_ll;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_ll || !ll_valid) begin
      wait_cnt_d = '0;
    end else if (ll_real && (wait_cnt_q != C_MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_comb begin
    rf_write_en_d   = 1'b0;
    rf_write_sel_d  = rf_write_sel_q;
    rf_write_data_d = rf_write_data_q;
    if (grant_ll) begin
      rf_write_en_d   = 1'b1;
      rf_write_sel_d  = ll_sel;
      rf_write_data_d = ll_data;
    end else if (grant_wb) begin
      rf_write_en_d   = 1'b1;
      rf_write_sel_d  = wb_sel;
      rf_write_data_d = wb_data;
    end
  end

  // Set is applied after clear so a re-issued op to the same register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (grant_ll) begin
      busy_d[ll_sel] = 1'b0;
    end
    if (mark_en && (mark_sel != '0)) begin
      busy_d[mark_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q      <= '0;
      rf_write_en_q   <= 1'b0;
      rf_write_sel_q  <= '0;
      rf_write_data_q <= '0;
      busy_q          <= '0;
    end else begin
      wait_cnt_q      <= wait_cnt_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_write_sel_q  <= rf_write_sel_d;
      rf_write_data_q <= rf_write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign rf_write_en   = rf_write_en_q;
  assign rf_write_sel  = rf_write_sel_q;
  assign rf_write_data = rf_write_data_q;
  assign busy_mask     = busy_q;

`ifdef REGFILE_WRITE_SCHED_HAZARD_CHECK_EN
  logic hazard_set;
  logic hazard_d, hazard_q;

  always_comb begin
    hazard_set = (grant_wb & busy_q[wb_sel]) |
                 (mark_en & (mark_sel != '0) & busy_q[mark_sel]);
    hazard_d   = hazard_q | hazard_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_q <= 1'b0;
    end else begin
      hazard_q <= hazard_d;
    end
  end

  assign hazard_err = hazard_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && hazard_set) begin
      $error("regfile_write_sched: write hazard on busy register");
    end
  end
`endif
`else
  assign hazard_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_sched
// Purpose  : Directed self-checking bench for regfile_write_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_sched;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          ll_valid;
  logic [SW-1:0] ll_sel;
  logic [DW-1:0] ll_data;
  logic          ll_ready;
  logic          mark_en;
  logic [SW-1:0] mark_sel;
  logic [NR-1:0] busy_mask;
  logic          rf_write_en;
  logic [SW-1:0] rf_write_sel;
  logic [DW-1:0] rf_write_data;
  logic          hazard_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_WRITE_SCHED_HAZARD_CHECK_EN
  localparam logic HAZ_EXP = 1'b1;
`else
  localparam logic HAZ_EXP = 1'b0;
`endif

  regfile_write_sched #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .MAX_WAIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .wb_stall(wb_stall),
    .ll_valid(ll_valid), .ll_sel(ll_sel), .ll_data(ll_data), .ll_ready(ll_ready),
    .mark_en(mark_en), .mark_sel(mark_sel), .busy_mask(busy_mask),
    .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel),
    .rf_write_data(rf_write_data), .hazard_err(hazard_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    wb_valid = 0; wb_sel = '0; wb_data = '0;
    ll_valid = 0; ll_sel = '0; ll_data = '0;
    mark_en  = 0; mark_sel = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    wb_valid = 1; wb_sel = 4'd3; ll_valid = 1; ll_sel = 4'd5;
    #1;
    n_checks++;
    if ({ll_ready, wb_stall} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hs: got ready/stall=%b expected 00", {ll_ready, wb_stall});
    end
    step();
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data} !== '0) begin
      n_fail++; $display("FAIL reset_rf: got en=%b sel=%0d data=%h expected 0/0/0",
                         rf_write_en, rf_write_sel, rf_write_data);
    end
    n_checks++;
    if ({busy_mask, hazard_err} !== '0) begin
      n_fail++; $display("FAIL reset_busy: got busy=%h haz=%b expected 0/0", busy_mask, hazard_err);
    end
    idle();
    rst = 1'b0;
    step();
  endtask

  task automatic test_wb_only();
    wb_valid = 1; wb_sel = 4'd5; wb_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL wb_only_stall: got %b expected 0", wb_stall);
    end
    step();
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b1, 4'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wb_only_rf: got en=%b sel=%0d data=%h expected 1/5/deadbeef",
                         rf_write_en, rf_write_sel, rf_write_data);
    end
    idle();
    step();
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b0, 4'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wb_only_hold: got en=%b sel=%0d data=%h expected 0/5/deadbeef",
                         rf_write_en, rf_write_sel, rf_write_data);
    end
  endtask

  task automatic test_contention();
    for (int c = 0; c < 4; c++) begin
      wb_valid = 1; wb_sel = 4'd2; wb_data = 32'hA0 + c;
      ll_valid = 1; ll_sel = 4'd7; ll_data = 32'h1234;
      #1;
      n_checks++;
      if ({ll_ready, wb_stall} !== {2{c == 3}}) begin
        n_fail++; $display("FAIL contention_hs cyc%0d: got ready/stall=%b expected %b",
                           c, {ll_ready, wb_stall}, {2{c == 3}});
      end
      step();
      n_checks++;
      if (c < 3) begin
        if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b1, 4'd2, 32'hA0 + c}) begin
          n_fail++; $display("FAIL contention_rf cyc%0d: got en=%b sel=%0d data=%h expected 1/2/%h",
                             c, rf_write_en, rf_write_sel, rf_write_data, 32'hA0 + c);
        end
      end else begin
        if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b1, 4'd7, 32'h1234}) begin
          n_fail++; $display("FAIL contention_rf cyc%0d: got en=%b sel=%0d data=%h expected 1/7/1234",
                             c, rf_write_en, rf_write_sel, rf_write_data);
        end
      end
    end
    idle();
    step();
  endtask

  task automatic test_scoreboard();
    mark_en = 1; mark_sel = 4'd9;
    step();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0200) begin
      n_fail++; $display("FAIL sb_set: got busy=%h expected 0200", busy_mask);
    end
    ll_valid = 1; ll_sel = 4'd9; ll_data = 32'hCAFE0009;
    #1;
    n_checks++;
    if (ll_ready !== 1'b1) begin
      n_fail++; $display("FAIL sb_grant: got ll_ready=%b expected 1", ll_ready);
    end
    step();
    n_checks++;
    if ({busy_mask, rf_write_en, rf_write_sel} !== {16'h0000, 1'b1, 4'd9}) begin
      n_fail++; $display("FAIL sb_clear: got busy=%h en=%b sel=%0d expected 0000/1/9",
                         busy_mask, rf_write_en, rf_write_sel);
    end
    // Re-mark 9 while its pending write is being granted.
    mark_en = 1; mark_sel = 4'd9;
    ll_valid = 1; ll_sel = 4'd9; ll_data = 32'h9;
    step();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0200) begin
      n_fail++; $display("FAIL sb_set_wins: got busy=%h expected 0200", busy_mask);
    end
    wb_valid = 1; wb_sel = 4'd9; wb_data = 32'h77;
    step();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0200) begin
      n_fail++; $display("FAIL sb_wb_no_clear: got busy=%h expected 0200", busy_mask);
    end
    ll_valid = 1; ll_sel = 4'd9; ll_data = 32'h9;
    step();
    idle();
    n_checks++;
    if (busy_mask !== 16'h0000) begin
      n_fail++; $display("FAIL sb_final_clear: got busy=%h expected 0000", busy_mask);
    end
  endtask

  task automatic test_zero_reg();
    wb_valid = 1; wb_sel = 4'd0; wb_data = 32'h1111;
    ll_valid = 1; ll_sel = 4'd4; ll_data = 32'h4444;
    #1;
    n_checks++;
    if ({ll_ready, wb_stall} !== 2'b10) begin
      n_fail++; $display("FAIL zero_wb_hs: got ready/stall=%b expected 10", {ll_ready, wb_stall});
    end
    step();
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b1, 4'd4, 32'h4444}) begin
      n_fail++; $display("FAIL zero_wb_rf: got en=%b sel=%0d data=%h expected 1/4/4444",
                         rf_write_en, rf_write_sel, rf_write_data);
    end
    idle();
    ll_valid = 1; ll_sel = 4'd0; ll_data = 32'h5555;
    #1;
    n_checks++;
    if (ll_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_ll_ready: got %b expected 1", ll_ready);
    end
    step();
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b0, 4'd4, 32'h4444}) begin
      n_fail++; $display("FAIL zero_ll_rf: got en=%b sel=%0d data=%h expected 0/4/4444",
                         rf_write_en, rf_write_sel, rf_write_data);
    end
    idle();
    wb_valid = 1; wb_sel = 4'd0; wb_data = 32'h6666;
    step();
    idle();
    n_checks++;
    if ({rf_write_en, busy_mask} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL zero_wb_only: got en=%b busy=%h expected 0/0000", rf_write_en, busy_mask);
    end
  endtask

  task automatic test_async_reset();
    for (int r = 4; r < 8; r++) begin
      mark_en = 1; mark_sel = SW'(r);
      step();
    end
    idle();
    n_checks++;
    if (busy_mask !== 16'h00F0) begin
      n_fail++; $display("FAIL ar_busy_pre: got busy=%h expected 00f0", busy_mask);
    end
    // Two lost LL cycles leave wait_cnt at 2 with WB written.
    wb_valid = 1; wb_sel = 4'd2; wb_data = 32'h55;
    ll_valid = 1; ll_sel = 4'd9; ll_data = 32'h99;
    step();
    step();
    n_checks++;
    if ({rf_write_en, rf_write_sel, ll_ready} !== {1'b1, 4'd2, 1'b0}) begin
      n_fail++; $display("FAIL ar_pre: got en=%b sel=%0d ready=%b expected 1/2/0",
                         rf_write_en, rf_write_sel, ll_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data, busy_mask} !== '0) begin
      n_fail++; $display("FAIL ar_async_regs: got en=%b sel=%0d data=%h busy=%h expected all 0",
                         rf_write_en, rf_write_sel, rf_write_data, busy_mask);
    end
    n_checks++;
    if ({ll_ready, wb_stall, hazard_err} !== 3'b000) begin
      n_fail++; $display("FAIL ar_async_comb: got ready/stall/haz=%b expected 000",
                         {ll_ready, wb_stall, hazard_err});
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (ll_ready !== (c == 3)) begin
        n_fail++; $display("FAIL ar_recount cyc%0d: got ll_ready=%b expected %b", c, ll_ready, c == 3);
      end
      step();
    end
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data} !== {1'b1, 4'd9, 32'h99}) begin
      n_fail++; $display("FAIL ar_ll_write: got en=%b sel=%0d data=%h expected 1/9/99",
                         rf_write_en, rf_write_sel, rf_write_data);
    end
    idle();
    step();
  endtask

  task automatic test_hazard();
    mark_en = 1; mark_sel = 4'd3;
    step();
    idle();
    wb_valid = 1; wb_sel = 4'd3; wb_data = 32'h33;
    step();
    idle();
    n_checks++;
    if (hazard_err !== HAZ_EXP) begin
      n_fail++; $display("FAIL hazard_set: got %b expected %b", hazard_err, HAZ_EXP);
    end
    ll_valid = 1; ll_sel = 4'd3; ll_data = 32'h3;
    step();
    idle();
    step();
    n_checks++;
    if ({hazard_err, busy_mask} !== {HAZ_EXP, 16'h0000}) begin
      n_fail++; $display("FAIL hazard_sticky: got haz=%b busy=%h expected %b/0000",
                         hazard_err, busy_mask, HAZ_EXP);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (hazard_err !== 1'b0) begin
      n_fail++; $display("FAIL hazard_rst: got %b expected 0", hazard_err);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_scoreboard();
    test_zero_reg();
    test_async_reset();
    test_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Scheduler for the register file's single synchronous write port.
- Shares the port between two sources:
  - the in-order writeback stage (WB);
  - the long-latency result path (LL: multiply/divide/load return).
- Keeps a pending-write scoreboard of registers awaiting LL results; the issue stage uses it for stall decisions.
- Sits between the pipeline/LL units and the register file's write_en/write_sel/write_data inputs.

Parameters:
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 16, number of architectural registers; register 0 is hardwired zero.
- SEL_WIDTH, 4, register select width, equal to log2(NUM_REGS).
- MAX_WAIT, 3, consecutive lost-arbitration cycles before LL is forced to win; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- wb_valid  in  1  WB write request this cycle.
- wb_sel  in  SEL_WIDTH  WB destination register.
- wb_data  in  DATA_WIDTH  WB data.
- wb_stall  out  1  WB request not accepted; pipeline must hold wb_* next cycle.
- ll_valid  in  1  LL write request; held stable until accepted.
- ll_sel  in  SEL_WIDTH  LL destination register.
- ll_data  in  DATA_WIDTH  LL data.
- ll_ready  out  1  LL request accepted this cycle (valid & ready = transfer).
- mark_en  in  1  issue stage dispatched an LL op.
- mark_sel  in  SEL_WIDTH  destination register of that op.
- busy_mask  out  NUM_REGS  bit i = register i has a pending LL write.
- rf_write_en  out  1  to register file write_en.
- rf_write_sel  out  SEL_WIDTH  to register file write_sel.
- rf_write_data  out  DATA_WIDTH  to register file write_data.
- hazard_err  out  1  sticky hazard flag (see Optional Feature).

Behaviour:
- Reset (async, while rst=1):
  - Registered outputs: rf_write_en=0, rf_write_sel=0, rf_write_data=0, busy_mask=0, hazard_err=0.
  - wait_cnt=0.
  - Combinational outputs: ll_ready=0, wb_stall=0.
- Zero-register requests (sel==0): accepted immediately, never occupy the port, and produce rf_write_en=0.
  - A WB sel 0 request never blocks LL.
  - An LL sel 0 request is granted whenever it is valid.
- Arbitration (combinational, same cycle):
  - wb_real = wb_valid & wb_sel!=0; ll_real = ll_valid & ll_sel!=0.
  - force_ll = ll_real & (wait_cnt == MAX_WAIT).
  - grant_ll = ll_real & (!wb_real | force_ll).
  - grant_wb = wb_real & !grant_ll.
  - ll_ready = ll_valid & (ll_sel==0 | grant_ll).
  - wb_stall = wb_real & grant_ll.
- Write port (one-cycle latency):
  - The granted request is registered into rf_* at the next edge.
  - With no grant, rf_write_en=0 and sel/data hold their previous values.
  - Read-after-write forwarding is the register file's job, not this block's.
- wait_cnt (2..4 bits, sized for MAX_WAIT):
  - Increments when ll_real & !grant_ll.
  - Clears on grant_ll, or when ll_valid=0.
  - Saturates at MAX_WAIT.
  - Worst-case WB stall: 1 cycle per MAX_WAIT+1 cycles.
- Scoreboard:
  - Set: bit mark_sel is set at the edge when mark_en & mark_sel!=0.
  - Clear: bit ll_sel is cleared at the edge when grant_ll. The clear is visible in busy_mask on the same cycle rf_write_en rises.
  - Set and clear of the same bit in one cycle: set wins (new op outstanding).
  - WB writes never clear busy bits.
- Reset mid-operation: everything returns to reset values; an in-flight LL request must be re-presented after rst deasserts.

Optional Feature:
- Macro: REGFILE_WRITE_SCHED_HAZARD_CHECK_EN.
- When defined, hazard_err is set (sticky until rst) at the edge following either:
  - grant_wb to a register whose busy bit is set (WAW), or
  - mark_en to an already-busy nonzero register.
- When defined, a simulation-only $error is also issued on the same conditions.
- When not defined, hazard_err is tied to 0 and no checking logic is built.

Test Plan:
- WB only: wb_valid=1, wb_sel=5, wb_data=0xDEADBEEF → next cycle rf_write_en=1, sel=5, data=0xDEADBEEF; wb_stall=0 throughout.
- Contention, MAX_WAIT=3: WB to reg 2 every cycle, LL valid to reg 7 with data 0x1234 held from cycle 0 → ll_ready=0 on cycles 0–2. Cycle 3: ll_ready=1, wb_stall=1. Cycle 4: rf_write_sel=7, data=0x1234.
- Scoreboard: mark_en sel=9 → busy_mask=0x0200. LL to reg 9 is granted at cycle N → busy_mask=0x0000 and rf_write_en=1/sel=9 together at N+1. Same-cycle mark sel=9 with LL grant to sel=9 → bit 9 stays 1.
- Zero register: WB sel=0 with LL sel=4 valid → ll_ready=1 same cycle, wb_stall=0, rf_write_sel=4 next cycle. LL sel=0 alone → ll_ready=1, rf_write_en stays 0.
- Async reset mid-operation: busy_mask=0x00F0, wait_cnt=2, rf_write_en=1; assert rst between edges → all outputs 0 immediately, without waiting for a clock edge. After deassert, an LL request is granted only after MAX_WAIT losses counted from 0.
- Hazard check (macro defined): mark sel=3, then WB to reg 3 → hazard_err=1 next cycle and stays 1 until rst. Macro undefined → hazard_err=0 always.
